lrelu_beats_sequencer: RTL and testbench

Parametrised successor to the LeakyReLU config-beat counter. Walks the config beat stream for one LReLU block: D register, then BRAM_A, then the BRAM_B tiles indexed (clr_i, mtb, w_addr).
- Generalised to independent kernel height and width.
- Takes a latched per-block config and a valid/ready beat handshake.
- Reports per-beat position, a running beat count, a last-beat flag and a done pulse.
Sits between the config DMA stream and the LReLU parameter memories; its outputs drive the write enables and addresses.

---
 rtl/lrelu_beats_pkg.sv | 76 +++++++
 rtl/lrelu_beats_sequencer_reg.sv | 22 ++
 rtl/lrelu_beats_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_lrelu_beats_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lrelu_beats_pkg.sv
// Constant helpers and shared types for the LeakyReLU config-beat sequencer.
// All beat counts are computed from kernel half-sizes (kh2/kw2) and MEMBERS.
package lrelu_beats_pkg;

  typedef enum logic [1:0] {
    Idle  = 2'd0,
    RegD  = 2'd1,
    BramA = 2'd2,
    BramB = 2'd3
  } w_sel_e;

  function automatic int int_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int int_min(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // BRAM_A beats: ceil(2/kw)
  function automatic int a_beats(input int kw2);
    return (kw2 == 0) ? 2 : 1;
  endfunction

  // BRAM_B beats per (clr_i, mtb) tile: ceil(2*floor(M/kw) / floor(M/(2c+1)))
  function automatic int b_beats(input int c, input int kw2, input int members);
    int words;
    int per;
    words = 2 * (members / (2 * kw2 + 1));
    per   = members / (2 * c + 1);
    if (per < 1) per = 1;
    return (words + per - 1) / per;
  endfunction

  function automatic int clr_last(input int kh2, input int kw2);
    return int_max(kh2, kw2);
  endfunction

  function automatic int mtb_last(input int c, input int kh2);
    return int_min(2 * c, 2 * kh2);
  endfunction

  function automatic int total_beats(input int kh2, input int kw2, input int members);
    int t;
    t = 1 + a_beats(kw2);
    for (int c = 0; c <= clr_last(kh2, kw2); c++) begin
      t += (mtb_last(c, kh2) + 1) * b_beats(c, kw2, members);
    end
    return t;
  endfunction

  function automatic int total_max(input int kh_max, input int kw_max, input int members);
    int m;
    m = 0;
    for (int h = 0; h <= kh_max / 2; h++) begin
      for (int w = 0; w <= kw_max / 2; w++) begin
        m = int_max(m, total_beats(h, w, members));
      end
    end
    return m;
  endfunction

  // Largest per-tile B beat count over every reachable (c, kw2); at least 2 so that
  // BRAM_A's two-beat case always fits in w_addr.
  function automatic int max_b_beats(input int kh_max, input int kw_max, input int members);
    int m;
    m = 2;
    for (int c = 0; c <= int_max(kh_max, kw_max) / 2; c++) begin
      for (int w = 0; w <= kw_max / 2; w++) begin
        m = int_max(m, b_beats(c, w, members));
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/lrelu_beats_sequencer_reg.sv
// Plain async-reset register with a parametrised reset value.
module lrelu_beats_sequencer_reg #(
  parameter int unsigned      WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  // State flop, cleared asynchronously to RESET_VALUE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_q <= RESET_VALUE;
    else         q_q <= d_i;
  end

  assign q_o = q_q;

endmodule

// File: rtl/lrelu_beats_sequencer.sv
// Walks the config beat stream of one LReLU block: REG_D, BRAM_A, then the
// BRAM_B tiles ordered by (clr_i, mtb, w_addr). Outputs drive parameter-memory
// write enables and addresses.
module lrelu_beats_sequencer
  import lrelu_beats_pkg::*;
#(
  parameter int unsigned MEMBERS  = 12,
  parameter int unsigned KH_MAX   = 3,
  parameter int unsigned KW_MAX   = 3,
  parameter int unsigned BITS_KH2 = $clog2(KH_MAX / 2 + 1),
  parameter int unsigned BITS_KW2 = $clog2(KW_MAX / 2 + 1),
  parameter int unsigned BITS_KH  = $clog2(KH_MAX),
  localparam int unsigned BITS_CLR_I =
      $clog2(int_max(int'(KH_MAX), int'(KW_MAX)) / 2 + 1),
  localparam int unsigned BITS_W_ADDR =
      $clog2(max_b_beats(int'(KH_MAX), int'(KW_MAX), int'(MEMBERS))),
  localparam int unsigned BITS_BEAT_CNT =
      $clog2(total_max(int'(KH_MAX), int'(KW_MAX), int'(MEMBERS)) + 1)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic [BITS_KH2-1:0]      kh2,
  input  logic [BITS_KW2-1:0]      kw2,
  input  logic                     clear,
  input  logic                     beat_valid,
  output logic                     beat_ready,
  output logic [1:0]               w_sel,
  output logic [BITS_CLR_I-1:0]    clr_i,
  output logic [BITS_KH-1:0]       mtb,
  output logic [BITS_W_ADDR-1:0]   w_addr,
  output logic [BITS_BEAT_CNT-1:0] beat_cnt,
  output logic                     last,
  output logic                     done,
  output logic                     cfg_err
);

  localparam int KH2_TOP = int'(KH_MAX / 2);
  localparam int KW2_TOP = int'(KW_MAX / 2);
  localparam int CLR_TOP = int_max(int'(KH_MAX), int'(KW_MAX)) / 2;
  localparam int unsigned CLR_ENT = 1 << BITS_CLR_I;
  localparam int unsigned KW2_ENT = 1 << BITS_KW2;
  localparam logic [BITS_BEAT_CNT-1:0] CNT_SAT =
      BITS_BEAT_CNT'(total_max(int'(KH_MAX), int'(KW_MAX), int'(MEMBERS)));

  logic [1:0]               w_sel_q, w_sel_d;
  logic [BITS_CLR_I-1:0]    clr_i_q, clr_i_d;
  logic [BITS_KH-1:0]       mtb_q, mtb_d;
  logic [BITS_W_ADDR-1:0]   w_addr_q, w_addr_d;
  logic [BITS_BEAT_CNT-1:0] beat_cnt_q, beat_cnt_d;
  logic [BITS_KH2-1:0]      kh2_q, kh2_d;
  logic [BITS_KW2-1:0]      kw2_q, kw2_d;
  logic                     done_q, done_d;
  logic                     cfg_err_q, cfg_err_d;

  logic                     fire;
  logic                     last_c;
  logic                     cfg_ok;
  logic [BITS_W_ADDR-1:0]   a_last_c;
  logic [BITS_W_ADDR-1:0]   b_last_c;
  logic [BITS_KH-1:0]       mtb_last_c;
  logic [BITS_CLR_I-1:0]    clr_last_c;

  // B_BEATS(c, kw2) - 1, padded to the full index range; unreachable slots are 0.
  logic [BITS_W_ADDR-1:0] b_last_lut [CLR_ENT][KW2_ENT];

  for (genvar c = 0; c < CLR_ENT; c++) begin : g_lut_c
    for (genvar k = 0; k < KW2_ENT; k++) begin : g_lut_k
      if (c <= CLR_TOP && k <= KW2_TOP) begin : g_valid
        assign b_last_lut[c][k] = BITS_W_ADDR'(b_beats(c, k, int'(MEMBERS)) - 1);
      end else begin : g_pad
        assign b_last_lut[c][k] = '0;
      end
    end
  end

  assign beat_ready = (w_sel_q != Idle);
  assign fire       = beat_valid && beat_ready;

  // Per-block limits derived from the latched kernel half-sizes.
  always_comb begin
    a_last_c   = BITS_W_ADDR'(a_beats(int'(kw2_q)) - 1);
    b_last_c   = b_last_lut[clr_i_q][kw2_q];
    mtb_last_c = BITS_KH'(mtb_last(int'(clr_i_q), int'(kh2_q)));
    clr_last_c = BITS_CLR_I'(clr_last(int'(kh2_q), int'(kw2_q)));
    last_c     = (w_sel_q == BramB) && (clr_i_q == clr_last_c) &&
                 (mtb_q == mtb_last_c) && (w_addr_q == b_last_c);
    cfg_ok     = (int'(kh2) <= KH2_TOP) && (int'(kw2) <= KW2_TOP);
  end

  // Next-state: clear beats start and fire; indices nest w_addr < mtb < clr_i.
  always_comb begin
    w_sel_d    = w_sel_q;
    clr_i_d    = clr_i_q;
    mtb_d      = mtb_q;
    w_addr_d   = w_addr_q;
    beat_cnt_d = beat_cnt_q;
    kh2_d      = kh2_q;
    kw2_d      = kw2_q;
    done_d     = 1'b0;
    cfg_err_d  = 1'b0;
    if (clear) begin
      w_sel_d    = Idle;
      clr_i_d    = '0;
      mtb_d      = '0;
      w_addr_d   = '0;
      beat_cnt_d = '0;
      kh2_d      = '0;
      kw2_d      = '0;
    end else begin
      if (fire && (beat_cnt_q != CNT_SAT)) beat_cnt_d = beat_cnt_q + 1'b1;
      unique case (w_sel_e'(w_sel_q))
        Idle: begin
          if (start) begin
            if (cfg_ok) begin
              kh2_d      = kh2;
              kw2_d      = kw2;
              w_sel_d    = RegD;
              beat_cnt_d = '0;
              clr_i_d    = '0;
              mtb_d      = '0;
              w_addr_d   = '0;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
        RegD: begin
          if (fire) begin
            w_sel_d  = BramA;
            w_addr_d = '0;
          end
        end
        BramA: begin
          if (fire) begin
            if (w_addr_q == a_last_c) begin
              w_sel_d  = BramB;
              w_addr_d = '0;
              clr_i_d  = '0;
              mtb_d    = '0;
            end else begin
              w_addr_d = w_addr_q + 1'b1;
            end
          end
        end
        BramB: begin
          if (fire) begin
            if (w_addr_q == b_last_c) begin
              w_addr_d = '0;
              if (mtb_q == mtb_last_c) begin
                mtb_d = '0;
                if (clr_i_q == clr_last_c) begin
                  w_sel_d = Idle;
                  clr_i_d = '0;
                  done_d  = 1'b1;
                end else begin
                  clr_i_d = clr_i_q + 1'b1;
                end
              end else begin
                mtb_d = mtb_q + 1'b1;
              end
            end else begin
              w_addr_d = w_addr_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  lrelu_beats_sequencer_reg #(.WIDTH(2), .RESET_VALUE(Idle)) u_w_sel_reg (
    .clk_i(clk), .rst_ni(rstn), .d_i(w_sel_d), .q_o(w_sel_q)
  );
  lrelu_beats_sequencer_reg #(.WIDTH(BITS_CLR_I)) u_clr_i_reg (
    .clk_i(clk), .rst_ni(rstn), .d_i(clr_i_d), .q_o(clr_i_q)
  );
  lrelu_beats_sequencer_reg #(.WIDTH(BITS_KH)) u_mtb_reg (
    .clk_i(clk), .rst_ni(rstn), .d_i(mtb_d), .q_o(mtb_q)
  );
  lrelu_beats_sequencer_reg #(.WIDTH(BITS_W_ADDR)) u_w_addr_reg (
    .clk_i(clk), .rst_ni(rstn), .d_i(w_addr_d), .q_o(w_addr_q)
  );
  lrelu_beats_sequencer_reg #(.WIDTH(BITS_BEAT_CNT)) u_beat_cnt_reg (
    .clk_i(clk), .rst_ni(rstn), .d_i(beat_cnt_d), .q_o(beat_cnt_q)
  );
  lrelu_beats_sequencer_reg #(.WIDTH(BITS_KH2)) u_kh2_reg (
    .clk_i(clk), .rst_ni(rstn), .d_i(kh2_d), .q_o(kh2_q)
  );
  lrelu_beats_sequencer_reg #(.WIDTH(BITS_KW2)) u_kw2_reg (
    .clk_i(clk), .rst_ni(rstn), .d_i(kw2_d), .q_o(kw2_q)
  );
  lrelu_beats_sequencer_reg #(.WIDTH(1)) u_done_reg (
    .clk_i(clk), .rst_ni(rstn), .d_i(done_d), .q_o(done_q)
  );
  lrelu_beats_sequencer_reg #(.WIDTH(1)) u_cfg_err_reg (
    .clk_i(clk), .rst_ni(rstn), .d_i(cfg_err_d), .q_o(cfg_err_q)
  );

  assign w_sel    = w_sel_q;
  assign clr_i    = clr_i_q;
  assign mtb      = mtb_q;
  assign w_addr   = w_addr_q;
  assign beat_cnt = beat_cnt_q;
  assign last     = last_c;
  assign done     = done_q;
  assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_lrelu_beats_sequencer.sv
// Bench for lrelu_beats_sequencer (MEMBERS=12, KH_MAX=5, KW_MAX=5). The expected
// beat list of a block is built by nested loops over (clr, mtb, word).
module tb_lrelu_beats_sequencer;

  localparam int MEMBERS = 12;

  typedef struct packed {
    logic [1:0] sel;
    logic [1:0] clr;
    logic [2:0] mtb;
    logic [3:0] wa;
  } pos_t;

  logic       clk = 1'b0;
  logic       rstn, start, clear, beat_valid;
  logic [1:0] kh2, kw2;
  logic       beat_ready;
  logic [1:0] w_sel;
  logic [1:0] clr_i;
  logic [2:0] mtb;
  logic [3:0] w_addr;
  logic [6:0] beat_cnt;
  logic       last, done, cfg_err;

  int vectors = 0;
  int errors  = 0;
  pos_t exp_q[$];

  lrelu_beats_sequencer #(.MEMBERS(MEMBERS), .KH_MAX(5), .KW_MAX(5)) dut (
    .clk(clk), .rstn(rstn), .start(start), .kh2(kh2), .kw2(kw2), .clear(clear),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .w_sel(w_sel), .clr_i(clr_i),
    .mtb(mtb), .w_addr(w_addr), .beat_cnt(beat_cnt), .last(last), .done(done),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  function automatic int m_b_beats(input int c, input int kw2v);
    int words;
    int per;
    words = 2 * (MEMBERS / (2 * kw2v + 1));
    per   = MEMBERS / (2 * c + 1);
    return (words + per - 1) / per;
  endfunction

  // Reference: ordered list of every beat position in a block.
  task automatic build(input int kh2v, input int kw2v);
    int clast;
    int mlast;
    exp_q.delete();
    exp_q.push_back({2'd1, 2'd0, 3'd0, 4'd0});
    for (int a = 0; a < ((kw2v == 0) ? 2 : 1); a++) exp_q.push_back({2'd2, 2'd0, 3'd0, 4'(a)});
    clast = (kh2v > kw2v) ? kh2v : kw2v;
    for (int c = 0; c <= clast; c++) begin
      mlast = (2 * c < 2 * kh2v) ? 2 * c : 2 * kh2v;
      for (int m = 0; m <= mlast; m++)
        for (int w = 0; w < m_b_beats(c, kw2v); w++)
          exp_q.push_back({2'd3, 2'(c), 3'(m), 4'(w)});
    end
  endtask

  task automatic start_block(input int kh2v, input int kw2v);
    start = 1'b1;
    kh2   = 2'(kh2v);
    kw2   = 2'(kw2v);
    @(negedge clk);
    start = 1'b0;
    kh2   = 2'($urandom);
    kw2   = 2'($urandom);
  endtask

  // Walks one accepted block; pct is the percentage of idle beat_valid cycles.
  task automatic walk_block(input int kh2v, input int kw2v, input int pct, input bit chain,
                            input int nkh2, input int nkw2);
    int   idx;
    int   cyc;
    int   n;
    bit   fire;
    pos_t got;
    build(kh2v, kw2v);
    n   = exp_q.size();
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 40 * n + 50) begin
      got = {w_sel, clr_i, mtb, w_addr};
      vectors++;
      if (got !== exp_q[idx]) begin
        errors++;
        $display("FAIL position blk(%0d,%0d) beat %0d: got sel=%0d clr=%0d mtb=%0d wa=%0d, want sel=%0d clr=%0d mtb=%0d wa=%0d",
                 kh2v, kw2v, idx, got.sel, got.clr, got.mtb, got.wa,
                 exp_q[idx].sel, exp_q[idx].clr, exp_q[idx].mtb, exp_q[idx].wa);
      end
      vectors++;
      if (last !== (idx == n - 1)) begin
        errors++;
        $display("FAIL last blk(%0d,%0d) beat %0d: got %0b want %0b", kh2v, kw2v, idx, last,
                 (idx == n - 1));
      end
      vectors++;
      if (beat_cnt !== 7'(idx)) begin
        errors++;
        $display("FAIL beat_cnt blk(%0d,%0d) beat %0d: got %0d want %0d", kh2v, kw2v, idx,
                 beat_cnt, idx);
      end
      beat_valid = ($urandom_range(99) >= pct);
      fire       = beat_valid && beat_ready;
      @(negedge clk);
      if (fire) idx++;
      cyc++;
    end
    beat_valid = 1'b0;
    vectors++;
    if (idx < n) begin
      errors++;
      $display("FAIL timeout blk(%0d,%0d): reached beat %0d of %0d", kh2v, kw2v, idx, n);
    end
    vectors++;
    if ({done, w_sel, clr_i, mtb, w_addr, last} !== {1'b1, 2'd0, 2'd0, 3'd0, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL end_state blk(%0d,%0d): got done=%0b sel=%0d clr=%0d mtb=%0d wa=%0d last=%0b, want done=1 and all else 0",
               kh2v, kw2v, done, w_sel, clr_i, mtb, w_addr, last);
    end
    vectors++;
    if (beat_cnt !== 7'(n)) begin
      errors++;
      $display("FAIL final_cnt blk(%0d,%0d): got %0d want %0d", kh2v, kw2v, beat_cnt, n);
    end
    if (chain) begin
      start_block(nkh2, nkw2);
      vectors++;
      if ({done, w_sel, beat_cnt} !== {1'b0, 2'd1, 7'd0}) begin
        errors++;
        $display("FAIL chain_start: got done=%0b sel=%0d cnt=%0d want done=0 sel=1 cnt=0",
                 done, w_sel, beat_cnt);
      end
    end else begin
      @(negedge clk);
      vectors++;
      if ({done, w_sel, beat_cnt} !== {1'b0, 2'd0, 7'(n)}) begin
        errors++;
        $display("FAIL idle_hold: got done=%0b sel=%0d cnt=%0d want done=0 sel=0 cnt=%0d",
                 done, w_sel, beat_cnt, n);
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    vectors++;
    if ({beat_ready, w_sel, clr_i, mtb, w_addr, beat_cnt, last, done, cfg_err} !== 22'd0) begin
      errors++;
      $display("FAIL %s: got rdy=%0b sel=%0d clr=%0d mtb=%0d wa=%0d cnt=%0d last=%0b done=%0b err=%0b, want all 0",
               name, beat_ready, w_sel, clr_i, mtb, w_addr, beat_cnt, last, done, cfg_err);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b1; start = 1'b0; clear = 1'b0; beat_valid = 1'b0; kh2 = '0; kw2 = '0;
    #2 rstn = 1'b0;
    #1 check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_basic();
    start_block(1, 1); walk_block(1, 1, 0, 1'b0, 0, 0);  // 9 beats
    start_block(2, 1); walk_block(2, 1, 0, 1'b0, 0, 0);  // 29 beats, clr_i to 2
    start_block(0, 1); walk_block(0, 1, 0, 1'b0, 0, 0);  // 5 beats, mtb stays 0
    start_block(0, 0); walk_block(0, 0, 0, 1'b0, 0, 0);  // two-beat A and B
  endtask

  task automatic test_gaps();
    start_block(1, 1); walk_block(1, 1, 50, 1'b0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      int h;
      int w;
      h = $urandom_range(2);
      w = $urandom_range(2);
      start_block(h, w);
      walk_block(h, w, $urandom_range(60), 1'b0, 0, 0);
    end
  endtask

  task automatic test_clear_mid_b();
    start_block(1, 1);
    beat_valid = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if ({w_sel, clr_i} !== {2'd3, 2'd1}) begin
      errors++;
      $display("FAIL pre_clear: got sel=%0d clr=%0d want sel=3 clr=1", w_sel, clr_i);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    beat_valid = 1'b0;
    check_all_zero("clear_next");
    @(negedge clk);
    check_all_zero("clear_after");
  endtask

  task automatic test_cfg_err();
    start = 1'b1; kh2 = 2'd0; kw2 = 2'd3;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if ({cfg_err, w_sel} !== {1'b1, 2'd0}) begin
      errors++;
      $display("FAIL cfg_err_kw: got err=%0b sel=%0d want err=1 sel=0", cfg_err, w_sel);
    end
    start = 1'b1; kh2 = 2'd3; kw2 = 2'd0;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if ({cfg_err, w_sel} !== {1'b1, 2'd0}) begin
      errors++;
      $display("FAIL cfg_err_kh: got err=%0b sel=%0d want err=1 sel=0", cfg_err, w_sel);
    end
    @(negedge clk);
    check_all_zero("cfg_err_pulse");
  endtask

  task automatic test_reset_mid_a();
    start_block(0, 0);
    beat_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({w_sel, w_addr} !== {2'd2, 4'd1}) begin
      errors++;
      $display("FAIL pre_reset: got sel=%0d wa=%0d want sel=2 wa=1", w_sel, w_addr);
    end
    #2 rstn = 1'b0;
    #1 check_all_zero("async_reset");
    beat_valid = 1'b0;
    @(negedge clk);
    check_all_zero("reset_no_done");
    rstn = 1'b1;
  endtask

  task automatic test_back_to_back();
    start_block(1, 1);
    walk_block(1, 1, 0, 1'b1, 0, 1);
    walk_block(0, 1, 20, 1'b1, 2, 2);
    walk_block(2, 2, 0, 1'b0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_clear_mid_b();
    test_cfg_err();
    test_reset_mid_a();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
